spad_reader: RTL and testbench
==============================

Name: spad_reader

Overview:
- Read-side sequencer for a scratchpad FIFO. On a start command it pops exactly N words from the FIFO and presents them on a valid/ready stream to a PE/MAC consumer, marking the final word with last.
- Hides the FIFO's one-cycle registered pop latency behind a small credit-controlled output buffer.
- Sustains one word per cycle when the FIFO is non-empty and the consumer is ready.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of the output stream
- CNT_WIDTH, 8, width of the word-count command; max transfer 2^CNT_WIDTH-1 words
- BUF_DEPTH, 2, output buffer entries; must be >= 2 for full throughput

Ports:
- i_clk  in  1  clock, rising edge
- i_nrst  in  1  reset, asynchronous, active-low
- i_clear  in  1  synchronous abort/flush, highest priority after reset
- i_start  in  1  start command, sampled only in IDLE
- i_count  in  CNT_WIDTH  number of words to transfer, latched on accepted start
- o_busy  out  1  high in RUN or DRAIN
- o_done  out  1  one-cycle pulse when transfer completes
- o_fifo_pop_en  out  1  pop request to the FIFO
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_pop_data  in  DATA_WIDTH  FIFO registered pop output, valid the cycle after pop_en
- o_data  out  DATA_WIDTH  stream data (head of buffer)
- o_valid  out  1  stream valid
- o_last  out  1  high with the final word of the transfer
- i_ready  in  1  consumer ready; transfer occurs when o_valid && i_ready

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; buffer empty; inflight 0.
- States:
  - IDLE: accepts a start command.
  - RUN: issues pops.
  - DRAIN: all pops issued; waits until inflight == 0 and the buffer is empty.
- IDLE, i_start=1, i_count>0: latch pops_left=i_count and words_left=i_count; go to RUN next cycle.
- IDLE, i_start=1, i_count=0: o_done pulses the next cycle; no pops; stay IDLE.
- i_start while busy: ignored; no queuing.
- Pop rule: o_fifo_pop_en = RUN && !i_fifo_empty && pops_left>0 && (occ + inflight - consume) < BUF_DEPTH, where consume = o_valid && i_ready.
  - o_fifo_pop_en is combinational from registered state and inputs.
  - A pop decrements pops_left.
- inflight is a register, set in the cycle after a pop.
- While inflight=1, i_fifo_pop_data is written into the buffer at the end of that cycle.
- Latency: pop in cycle t → data on o_data with o_valid in cycle t+2. No bypass path.
- Buffer: in-order, BUF_DEPTH entries; simultaneous write and read in one cycle allowed; never overflows, guaranteed by the credit rule.
- o_last = o_valid && (words_left == 1). words_left decrements on each consume.
- RUN → DRAIN when pops_left reaches 0.
- DRAIN → IDLE on the consume of the last word; o_done pulses in the following cycle (first IDLE cycle).
- Throughput: with the FIFO non-empty and i_ready held high, one word per cycle after the 2-cycle fill.
- Backpressure: o_data and o_valid are held stable while o_valid && !i_ready.
- FIFO goes empty mid-transfer: pops stall and resume when i_fifo_empty=0; no error.
- i_clear (any state):
  - Next cycle: IDLE, buffer flushed, inflight cleared, counters zeroed.
  - No o_done pulse; o_fifo_pop_en is forced 0 in the i_clear cycle.
  - The FIFO's own clear is driven separately by the parent.
- Reset mid-transfer: immediate return to the reset state; no done.
- Counter width: pops_left and words_left are CNT_WIDTH bits; no wrap is possible since they only decrement from a latched value.

Decomposition:
- spad_pkg holds the state enum (IDLE, RUN, DRAIN) and a shared CNT_WIDTH default.
- One sub-module, spad_out_buf: a BUF_DEPTH-entry synchronous buffer with write, read, occupancy, and head data.
- spad_reader contains the FSM, counters, inflight flag and credit logic.

Test Plan:
- Streaming: FIFO preloaded 0x10..0x17, start count=8, i_ready=1 → pops in cycles 1–8; o_data 0x10..0x17 on consecutive cycles 3–10; o_last only with 0x17; o_done pulse cycle 11.
- Backpressure: count=4, i_ready toggles 1,0,0,1,... → each word held stable while not ready; no word dropped or duplicated; never more than BUF_DEPTH words buffered or in flight; output order 0x10..0x13.
- Underflow stall: FIFO holds 2 words, start count=4, 2 more words written 5 cycles later → 2 words delivered, pops stall while empty, remaining 2 delivered; o_last on the 4th word; a single o_done.
- Zero count and busy start: start count=0 → o_done next cycle, no pop_en; start count=3, then i_start again mid-transfer → second start ignored, exactly 3 pops.
- Abort: count=6, assert i_clear after 2 words consumed → pop_en 0 that cycle, o_valid 0 next cycle, o_busy 0, no o_done; a new start count=2 afterwards works normally.
- Reset mid-transfer: drop i_nrst asynchronously during RUN → all outputs 0 immediately; after release, IDLE and accepts a new start.

Source files
------------

// File: rtl/spad_pkg.sv
// ---------------------------------------------------------------------------
// spad_pkg
// Definitions shared by the scratchpad read sequencer and its output buffer.
//   spad_state_e      : sequencer states (IDLE / RUN / DRAIN)
//   SPAD_CNT_WIDTH    : default width of the word-count command
//   SPAD_DATA_WIDTH   : default FIFO / stream word width
//   SPAD_BUF_DEPTH    : default output buffer depth (>= 2 for full rate)
// ---------------------------------------------------------------------------
package spad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } spad_state_e;

  localparam int SPAD_CNT_WIDTH  = 8;
  localparam int SPAD_DATA_WIDTH = 8;
  localparam int SPAD_BUF_DEPTH  = 2;

endpackage : spad_pkg

// File: rtl/spad_out_buf.sv
// ---------------------------------------------------------------------------
// spad_out_buf
// Small in-order circular buffer between the FIFO pop data and the output
// stream. Write and read may happen in the same cycle. The caller guarantees
// it never writes when full nor reads when empty.
// Ports:
//   clk      in   clock, rising edge
//   nrst     in   asynchronous active-low reset
//   clear    in   synchronous flush (pointers and occupancy to zero)
//   wr_en    in   push wr_data at the end of the cycle
//   wr_data  in   DATA_WIDTH word to push
//   rd_en    in   pop the head entry at the end of the cycle
//   occ      out  number of valid entries (registered)
//   head     out  oldest entry (valid when occ != 0)
// ---------------------------------------------------------------------------
module spad_out_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]      occ_r;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Pointer and occupancy bookkeeping; clear empties the buffer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_en) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_en, rd_en})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Storage array; contents need no flush since occupancy gates validity.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en && !clear) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign occ  = occ_r;
  assign head = mem_r[rd_ptr_r];

endmodule : spad_out_buf

// File: rtl/spad_reader.sv
// ---------------------------------------------------------------------------
// spad_reader
// Read-side sequencer for a scratchpad FIFO. A start command with count N
// pops exactly N words and streams them out on a valid/ready interface,
// flagging the final word with o_last. The FIFO's one-cycle registered pop
// latency is absorbed by a credit-controlled output buffer so that a
// non-empty FIFO and a ready consumer give one word per cycle.
// Ports:
//   i_clk            in   clock, rising edge
//   i_nrst           in   asynchronous active-low reset
//   i_clear          in   synchronous abort/flush, no done pulse
//   i_start          in   start command, honoured only in IDLE
//   i_count          in   words to transfer, latched with the start
//   o_busy           out  transfer in progress (RUN or DRAIN)
//   o_done           out  one-cycle completion pulse
//   o_fifo_pop_en    out  FIFO pop request
//   i_fifo_empty     in   FIFO empty flag
//   i_fifo_pop_data  in   FIFO pop data, valid the cycle after a pop
//   o_data           out  stream data (zero when o_valid is low)
//   o_valid          out  stream valid
//   o_last           out  marks the final word of the transfer
//   i_ready          in   consumer ready
// ---------------------------------------------------------------------------
module spad_reader
  import spad_pkg::*;
#(
  parameter int DATA_WIDTH = SPAD_DATA_WIDTH,
  parameter int CNT_WIDTH  = SPAD_CNT_WIDTH,
  parameter int BUF_DEPTH  = SPAD_BUF_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic [CNT_WIDTH-1:0]  i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fifo_pop_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_pop_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int FILL_W = OCC_W + 1;

  spad_state_e           state_r;
  spad_state_e           state_nxt;
  logic [CNT_WIDTH-1:0]  pops_left_r;
  logic [CNT_WIDTH-1:0]  words_left_r;
  logic                  inflight_r;
  logic                  done_r;

  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  valid;
  logic                  consume;
  logic [FILL_W-1:0]     fill;
  logic [FILL_W-1:0]     fill_limit;
  logic                  credit_ok;
  logic                  pop;
  logic                  accept_start;
  logic                  zero_start;
  logic                  finish;

  spad_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_out_buf (
    .clk     (i_clk),
    .nrst    (i_nrst),
    .clear   (i_clear),
    .wr_en   (inflight_r),
    .wr_data (i_fifo_pop_data),
    .rd_en   (consume),
    .occ     (occ),
    .head    (head)
  );

  assign valid   = (occ != {OCC_W{1'b0}});
  assign consume = valid && i_ready;

  // A word is owed to the buffer for every entry held plus every pop still
  // in flight; a consume this cycle frees one slot, so it widens the limit
  // instead of being subtracted (keeps the arithmetic unsigned-safe).
  assign fill       = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_r};
  assign fill_limit = FILL_W'(BUF_DEPTH) + {{OCC_W{1'b0}}, consume};
  assign credit_ok  = (fill < fill_limit);

  // Next-state, pop request and completion events. Clear overrides all.
  always_comb begin
    state_nxt    = state_r;
    pop          = 1'b0;
    accept_start = 1'b0;
    zero_start   = 1'b0;
    finish       = 1'b0;
    if (i_clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            if (i_count != {CNT_WIDTH{1'b0}}) begin
              accept_start = 1'b1;
              state_nxt    = ST_RUN;
            end else begin
              zero_start = 1'b1;
              state_nxt  = ST_IDLE;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!i_fifo_empty && (pops_left_r != {CNT_WIDTH{1'b0}}) && credit_ok) begin
            pop = 1'b1;
            if (pops_left_r == CNT_WIDTH'(1)) begin
              state_nxt = ST_DRAIN;
            end else begin
              state_nxt = ST_RUN;
            end
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Consuming the last word implies nothing in flight or buffered.
          if (consume && (words_left_r == CNT_WIDTH'(1))) begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Pop and word counters, latched on an accepted start.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      pops_left_r  <= {CNT_WIDTH{1'b0}};
      words_left_r <= {CNT_WIDTH{1'b0}};
    end else if (i_clear) begin
      pops_left_r  <= {CNT_WIDTH{1'b0}};
      words_left_r <= {CNT_WIDTH{1'b0}};
    end else if (accept_start) begin
      pops_left_r  <= i_count;
      words_left_r <= i_count;
    end else begin
      if (pop) begin
        pops_left_r <= pops_left_r - CNT_WIDTH'(1);
      end
      if (consume) begin
        words_left_r <= words_left_r - CNT_WIDTH'(1);
      end
    end
  end

  // In-flight flag (pop data lands next cycle) and registered done pulse.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
    end else if (i_clear) begin
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      inflight_r <= pop;
      done_r     <= zero_start || finish;
    end
  end

  assign o_fifo_pop_en = pop;
  assign o_valid       = valid;
  assign o_data        = valid ? head : {DATA_WIDTH{1'b0}};
  assign o_last        = valid && (words_left_r == CNT_WIDTH'(1));
  assign o_busy        = (state_r != ST_IDLE);
  assign o_done        = done_r;

endmodule : spad_reader

// File: tb/tb_spad_reader.sv
module tb_spad_reader;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          start;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          pop_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_pop_data;
  logic [DW-1:0] data;
  logic          valid;
  logic          last;
  logic          ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spad_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BUF_DEPTH(BD)) dut (
    .i_clk           (clk),
    .i_nrst          (rst_n),
    .i_clear         (clear),
    .i_start         (start),
    .i_count         (count),
    .o_busy          (busy),
    .o_done          (done),
    .o_fifo_pop_en   (pop_en),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_pop_data (fifo_pop_data),
    .o_data          (data),
    .o_valid         (valid),
    .o_last          (last),
    .i_ready         (ready)
  );

  // FIFO model with registered pop output.
  logic [7:0] fmem [0:255];
  logic [7:0] fwr = 8'd0;
  logic [7:0] frd = 8'd0;
  assign fifo_empty = (fwr == frd);

  always @(posedge clk) begin
    if (pop_en && (fwr != frd)) begin
      fifo_pop_data <= fmem[frd];
      frd           <= frd + 8'd1;
    end
  end

  // Stream monitor: records consumed words and counts protocol anomalies.
  logic [7:0] out_data [0:255];
  logic       out_last [0:255];
  logic [7:0] cons_cnt   = 8'd0;
  int         pop_cnt    = 0;
  int         bad_pop    = 0;
  int         done_cnt   = 0;
  int         unstable   = 0;
  int         over       = 0;
  int         outst      = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outst      <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (pop_en) begin
        pop_cnt <= pop_cnt + 1;
        if (fifo_empty) bad_pop <= bad_pop + 1;
      end
      if (valid && ready) begin
        out_data[cons_cnt] <= data;
        out_last[cons_cnt] <= last;
        cons_cnt           <= cons_cnt + 8'd1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (prev_stall && (!valid || (data != prev_data))) unstable <= unstable + 1;
      prev_stall <= valid && !ready;
      prev_data  <= data;
      if (clear) begin
        outst <= 0;
      end else begin
        outst <= outst + int'(pop_en) - int'(valid && ready);
        if (outst + int'(pop_en) - int'(valid && ready) > BD) over <= over + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_fifo();
    fwr = frd;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[fwr] = d;
    fwr = fwr + 8'd1;
  endtask

  task automatic issue(input logic [CW-1:0] n);
    start = 1'b1;
    count = n;
    step();
    start = 1'b0;
    count = '0;
  endtask

  function automatic logic rpat(input int i);
    case (i % 4)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Steps until a new done pulse has been recorded or the bound expires.
  task automatic run_until_done(input int base, input int bound, input bit pattern, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!ok) begin
        ready = pattern ? rpat(i) : 1'b1;
        step();
        if (done_cnt > base) ok = 1'b1;
      end
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; count = '0; ready = 1'b1;
    #12;
    n_checks++;
    if ({busy, done, pop_en, valid, last, data} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 0", {busy, done, pop_en, valid, last, data});
    end
    rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    n_checks++;
    if ({busy, done, pop_en, valid} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle got %b exp 0000", {busy, done, pop_en, valid});
    end
  endtask

  task automatic test_streaming();
    logic [7:0] ed;
    step();
    flush_fifo();
    for (int k = 0; k < 8; k++) push(8'h10 + 8'(k));
    ready = 1'b1;
    issue(8'd8);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      ed = (c >= 3 && c <= 10) ? 8'(8'h10 + c - 3) : 8'h00;
      n_checks++;
      if (pop_en !== (c >= 1 && c <= 8)) begin
        n_fail++; $display("FAIL stream_pop c=%0d got %b", c, pop_en);
      end
      n_checks++;
      if (valid !== (c >= 3 && c <= 10)) begin
        n_fail++; $display("FAIL stream_valid c=%0d got %b", c, valid);
      end
      n_checks++;
      if (data !== ed) begin
        n_fail++; $display("FAIL stream_data c=%0d got %h exp %h", c, data, ed);
      end
      n_checks++;
      if (last !== (c == 10)) begin
        n_fail++; $display("FAIL stream_last c=%0d got %b", c, last);
      end
      n_checks++;
      if (done !== (c == 11)) begin
        n_fail++; $display("FAIL stream_done c=%0d got %b", c, done);
      end
      n_checks++;
      if (busy !== (c >= 1 && c <= 10)) begin
        n_fail++; $display("FAIL stream_busy c=%0d got %b", c, busy);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int b_pop, b_done, b_uns, b_over;
    logic [7:0] b_cons;
    step();
    flush_fifo();
    for (int k = 0; k < 4; k++) push(8'h10 + 8'(k));
    b_pop = pop_cnt; b_done = done_cnt; b_uns = unstable; b_over = over; b_cons = cons_cnt;
    issue(8'd4);
    run_until_done(b_done, 60, 1'b1, ok);
    step(); step();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout no done within bound"); end
    n_checks++;
    if (8'(cons_cnt - b_cons) !== 8'd4) begin
      n_fail++; $display("FAIL bp_count got %0d exp 4", 8'(cons_cnt - b_cons));
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_data[8'(b_cons + 8'(k))] !== 8'(8'h10 + k) ||
          out_last[8'(b_cons + 8'(k))] !== (k == 3)) begin
        n_fail++;
        $display("FAIL bp_word k=%0d got %h/%b exp %h/%b", k, out_data[8'(b_cons + 8'(k))],
                 out_last[8'(b_cons + 8'(k))], 8'(8'h10 + k), (k == 3));
      end
    end
    n_checks++;
    if (unstable - b_uns !== 0) begin
      n_fail++; $display("FAIL bp_stable got %0d unstable cycles exp 0", unstable - b_uns);
    end
    n_checks++;
    if (over - b_over !== 0) begin
      n_fail++; $display("FAIL bp_credit got %0d overfills exp 0", over - b_over);
    end
    n_checks++;
    if (pop_cnt - b_pop !== 4 || done_cnt - b_done !== 1) begin
      n_fail++; $display("FAIL bp_pops_done got %0d/%0d exp 4/1", pop_cnt - b_pop, done_cnt - b_done);
    end
  endtask

  task automatic test_underflow();
    bit ok;
    int b_pop, b_done, b_bad;
    logic [7:0] b_cons;
    step();
    flush_fifo();
    push(8'h20); push(8'h21);
    b_pop = pop_cnt; b_done = done_cnt; b_bad = bad_pop; b_cons = cons_cnt;
    ready = 1'b1;
    issue(8'd4);
    step(); step(); step();
    @(negedge clk);
    n_checks++;
    if (pop_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL uf_stall got pop=%b busy=%b exp 0/1", pop_en, busy);
    end
    step();
    push(8'h22); push(8'h23);
    run_until_done(b_done, 40, 1'b0, ok);
    step(); step();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL uf_timeout no done within bound"); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_data[8'(b_cons + 8'(k))] !== 8'(8'h20 + k) ||
          out_last[8'(b_cons + 8'(k))] !== (k == 3)) begin
        n_fail++;
        $display("FAIL uf_word k=%0d got %h/%b exp %h/%b", k, out_data[8'(b_cons + 8'(k))],
                 out_last[8'(b_cons + 8'(k))], 8'(8'h20 + k), (k == 3));
      end
    end
    n_checks++;
    if (pop_cnt - b_pop !== 4 || done_cnt - b_done !== 1 || bad_pop - b_bad !== 0 ||
        8'(cons_cnt - b_cons) !== 8'd4) begin
      n_fail++;
      $display("FAIL uf_totals got pops=%0d done=%0d badpop=%0d words=%0d exp 4/1/0/4",
               pop_cnt - b_pop, done_cnt - b_done, bad_pop - b_bad, 8'(cons_cnt - b_cons));
    end
  endtask

  task automatic test_zero_and_busy();
    bit ok;
    int b_pop, b_done;
    logic [7:0] b_cons;
    step();
    issue(8'd0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || pop_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done got done=%b pop=%b busy=%b exp 1/0/0", done, pop_en, busy);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL zero_pulse got done=%b exp 0", done);
    end
    step();
    flush_fifo();
    for (int k = 0; k < 6; k++) push(8'h30 + 8'(k));
    b_pop = pop_cnt; b_done = done_cnt; b_cons = cons_cnt;
    issue(8'd3);
    step();
    start = 1'b1; count = 8'd5;
    step();
    start = 1'b0; count = '0;
    run_until_done(b_done, 40, 1'b0, ok);
    step(); step(); step();
    @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL busy_timeout no done within bound"); end
    n_checks++;
    if (pop_cnt - b_pop !== 3 || 8'(cons_cnt - b_cons) !== 8'd3 || done_cnt - b_done !== 1) begin
      n_fail++; $display("FAIL busy_start got pops=%0d words=%0d done=%0d exp 3/3/1",
                         pop_cnt - b_pop, 8'(cons_cnt - b_cons), done_cnt - b_done);
    end
    n_checks++;
    if (8'(fwr - frd) !== 8'd3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_left got fifo=%0d busy=%b exp 3/0", 8'(fwr - frd), busy);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit reached;
    int b_done;
    logic [7:0] b_cons;
    step();
    flush_fifo();
    for (int k = 0; k < 6; k++) push(8'h40 + 8'(k));
    b_done = done_cnt; b_cons = cons_cnt;
    ready = 1'b1;
    issue(8'd6);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!reached) begin
        if (8'(cons_cnt - b_cons) >= 8'd2) reached = 1'b1;
        else step();
      end
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL abort_timeout two words not consumed"); end
    clear = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pop_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_pop got %b exp 0", pop_en);
    end
    step();
    clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || data !== 8'h00) begin
      n_fail++; $display("FAIL abort_idle got valid=%b busy=%b last=%b data=%h exp 0", valid, busy, last, data);
    end
    step(); step(); step(); step();
    n_checks++;
    if (done_cnt - b_done !== 0) begin
      n_fail++; $display("FAIL abort_nodone got %0d done pulses exp 0", done_cnt - b_done);
    end
    flush_fifo();
    push(8'h50); push(8'h51);
    b_done = done_cnt; b_cons = cons_cnt;
    issue(8'd2);
    run_until_done(b_done, 30, 1'b0, ok);
    step();
    n_checks++;
    if (!ok || 8'(cons_cnt - b_cons) !== 8'd2 || out_data[b_cons] !== 8'h50 ||
        out_data[8'(b_cons + 8'd1)] !== 8'h51 || out_last[b_cons] !== 1'b0 ||
        out_last[8'(b_cons + 8'd1)] !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart got ok=%b words=%0d d0=%h d1=%h exp 1/2/50/51",
                         ok, 8'(cons_cnt - b_cons), out_data[b_cons], out_data[8'(b_cons + 8'd1)]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b_done;
    logic [7:0] b_cons;
    step();
    flush_fifo();
    for (int k = 0; k < 8; k++) push(8'h60 + 8'(k));
    b_done = done_cnt;
    ready = 1'b1;
    issue(8'd8);
    step(); step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pop_en, valid, last, data} !== 13'd0) begin
      n_fail++; $display("FAIL rstmid_outputs got %b exp 0", {busy, done, pop_en, valid, last, data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done_cnt - b_done !== 0) begin
      n_fail++; $display("FAIL rstmid_idle got busy=%b done=%0d exp 0/0", busy, done_cnt - b_done);
    end
    step();
    flush_fifo();
    push(8'h70); push(8'h71); push(8'h72);
    b_done = done_cnt; b_cons = cons_cnt;
    issue(8'd3);
    run_until_done(b_done, 30, 1'b0, ok);
    step(); step();
    n_checks++;
    if (!ok || 8'(cons_cnt - b_cons) !== 8'd3 || done_cnt - b_done !== 1) begin
      n_fail++; $display("FAIL rstmid_restart got ok=%b words=%0d done=%0d exp 1/3/1",
                         ok, 8'(cons_cnt - b_cons), done_cnt - b_done);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_data[8'(b_cons + 8'(k))] !== 8'(8'h70 + k)) begin
        n_fail++; $display("FAIL rstmid_word k=%0d got %h exp %h", k,
                           out_data[8'(b_cons + 8'(k))], 8'(8'h70 + k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_underflow();
    test_zero_and_busy();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spad_reader
